// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote, configurable
// data width, optional parity, 1/2 stop bits, break detection, config latched per frame.
module uart_rx_param #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  Parity_en,
   input  logic                  Parity_type,
   input  logic                  Two_stop,
   input  logic [PRESCALE_W-1:0] Prescale,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  Parity_error,
   output logic                  Stop_error,
   output logic                  Break_det
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0]         BIT_ONE  = BW'(1);
   localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
   } state_e;

   state_e                  state_q;
   logic [1:0]              sync_q;
   logic [PRESCALE_W-1:0]   edge_q, presc_q;
   logic [BW-1:0]           bit_q;
   logic [DATA_WIDTH-1:0]   data_q, p_data_q;
   logic                    smp0_q, smp1_q;
   logic                    pen_q, ptype_q, two_q;
   logic                    err_p_q, err_s_q, pvote_q, armed_q;
   logic                    dv_q, pe_q, se_q, bk_q;

   logic                    rx_s, vote, at_mid, at_end, brk;
   logic [PRESCALE_W-1:0]   half, half_m1, half_p1, last, edge_d;

   assign rx_s    = sync_q[1];
   assign half    = presc_q >> 1;
   assign half_m1 = half - ONE;
   assign half_p1 = half + ONE;
   assign last    = presc_q - ONE;
   assign at_mid  = (edge_q == half_p1);
   assign at_end  = (edge_q == last);
   assign edge_d  = at_end ? '0 : edge_q + ONE;
   // Third sample is the live synchronised bit, so the vote resolves on the mid+1 cycle.
   assign vote    = (smp0_q & smp1_q) | (smp0_q & rx_s) | (smp1_q & rx_s);
   assign brk     = (data_q == '0) & err_s_q & (!pvote_q | !pen_q);

   assign P_DATA       = p_data_q;
   assign DATA_VALID   = dv_q;
   assign Parity_error = pe_q;
   assign Stop_error   = se_q;
   assign Break_det    = bk_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= S_IDLE;
         sync_q   <= 2'b11;
         edge_q   <= '0;
         presc_q  <= '0;
         bit_q    <= '0;
         data_q   <= '0;
         p_data_q <= '0;
         smp0_q   <= 1'b1;
         smp1_q   <= 1'b1;
         pen_q    <= 1'b0;
         ptype_q  <= 1'b0;
         two_q    <= 1'b0;
         err_p_q  <= 1'b0;
         err_s_q  <= 1'b0;
         pvote_q  <= 1'b0;
         armed_q  <= 1'b1;
         dv_q     <= 1'b0;
         pe_q     <= 1'b0;
         se_q     <= 1'b0;
         bk_q     <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], RX_IN};
         dv_q   <= 1'b0;
         pe_q   <= 1'b0;
         se_q   <= 1'b0;
         bk_q   <= 1'b0;
         if (state_q != S_IDLE) edge_q <= edge_d;
         if (edge_q == half_m1) smp0_q <= rx_s;
         if (edge_q == half)    smp1_q <= rx_s;
         case (state_q)
            S_IDLE: begin
               // After a break the line must be seen high before a new start is accepted.
               if (rx_s) armed_q <= 1'b1;
               else if (armed_q) begin
                  state_q <= S_START;
                  edge_q  <= '0;
                  pen_q   <= Parity_en;
                  ptype_q <= Parity_type;
                  two_q   <= Two_stop;
                  presc_q <= Prescale;
                  err_p_q <= 1'b0;
                  err_s_q <= 1'b0;
                  pvote_q <= 1'b0;
               end
            end
            S_START: begin
               if (at_mid && vote) state_q <= S_IDLE;
               else if (at_end) begin
                  state_q <= S_DATA;
                  bit_q   <= '0;
               end
            end
            S_DATA: begin
               if (at_mid) data_q[bit_q] <= vote;
               if (at_end) begin
                  if (bit_q == LAST_BIT) state_q <= pen_q ? S_PARITY : S_STOP1;
                  else bit_q <= bit_q + BIT_ONE;
               end
            end
            S_PARITY: begin
               if (at_mid) begin
                  pvote_q <= vote;
                  err_p_q <= vote ^ (^data_q) ^ ptype_q;
               end
               if (at_end) state_q <= S_STOP1;
            end
            S_STOP1: begin
               if (at_mid) begin
                  err_s_q <= !vote;
                  if (!two_q) state_q <= S_DONE;
               end else if (at_end && two_q) state_q <= S_STOP2;
            end
            S_STOP2: begin
               if (at_mid) begin
                  err_s_q <= err_s_q | !vote;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               dv_q    <= !err_p_q & !err_s_q;
               pe_q    <= err_p_q;
               se_q    <= err_s_q;
               bk_q    <= brk;
               if (brk) armed_q <= 1'b0;
               if (!err_p_q && !err_s_q) p_data_q <= data_q;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
